// File: rtl/bus_mux_driver_pkg.sv
// Shared constants for the bus source mux.
// Source indices, widths and FSM state encoding.
package bus_mux_driver_pkg;

  localparam int NUM_SRC    = 24;
  localparam int DATA_WIDTH = 32;
  localparam int SEL_WIDTH  = 5;
  localparam int TIMEOUT    = 15;

  localparam int SRC_R0     = 0;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/bus_mux_driver_prio_encoder.sv
// Fixed-priority encoder, bit 0 highest.
// req -> idx of lowest set bit, any, multi.
module prio_encoder #(
  parameter int N  = 24,
  parameter int SW = 5
) (
  input  logic [N-1:0]  req,
  output logic [SW-1:0] idx,
  output logic          any,
  output logic          multi
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = SW'(i);
    end
  end

  assign any   = |req;
  // clearing the lowest set bit leaves something iff popcount > 1
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/bus_mux_driver.sv
// Registered source-side driver of the 32-bit datapath bus.
// src_out/src_data in; BusMuxOut, valid, sel, busy, sticky flags out.
module bus_mux_driver
  import bus_mux_driver_pkg::*;
#(
  parameter int NUM_SRC    = bus_mux_driver_pkg::NUM_SRC,
  parameter int DATA_WIDTH = bus_mux_driver_pkg::DATA_WIDTH,
  parameter int SEL_WIDTH  = bus_mux_driver_pkg::SEL_WIDTH,
  parameter int TIMEOUT    = bus_mux_driver_pkg::TIMEOUT
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [NUM_SRC-1:0]            src_out,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic                          bus_ack,
  output logic [DATA_WIDTH-1:0]         BusMuxOut,
  output logic                          bus_valid,
  output logic [SEL_WIDTH-1:0]          bus_sel,
  output logic                          busy,
  output logic                          contention,
  output logic                          timeout_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    valid_d, busy_d;
  logic [SEL_WIDTH-1:0]    sel_d;
  logic                    cont_d, terr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [SEL_WIDTH-1:0]    idx;
  logic                    any, multi;
  logic                    load;

  prio_encoder #(
    .N  (NUM_SRC),
    .SW (SEL_WIDTH)
  ) u_enc (
    .req   (src_out),
    .idx   (idx),
    .any   (any),
    .multi (multi)
  );

  // a new word may be taken from idle, or as an ack retires the old one
  assign load = any && ((state_q == IDLE) || bus_ack);

  always_comb begin
    state_d = state_q;
    data_d  = BusMuxOut;
    valid_d = bus_valid;
    sel_d   = bus_sel;
    busy_d  = busy;
    cont_d  = contention;
    terr_d  = timeout_err;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      DRIVE: begin
        if (bus_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            terr_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = DRIVE;
      data_d  = src_data[idx*DATA_WIDTH +: DATA_WIDTH];
      sel_d   = idx;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      cnt_d   = '0;
      if (multi) cont_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      BusMuxOut   <= '0;
      bus_valid   <= 1'b0;
      bus_sel     <= '0;
      busy        <= 1'b0;
      contention  <= 1'b0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      BusMuxOut   <= data_d;
      bus_valid   <= valid_d;
      bus_sel     <= sel_d;
      busy        <= busy_d;
      contention  <= cont_d;
      timeout_err <= terr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_mux_driver.sv
// Directed self-checking bench for bus_mux_driver.
// Linear stimulus, immediate assertions, one summary line.
module tb_bus_mux_driver;

  localparam int NS = 24;
  localparam int DW = 32;
  localparam int SW = 5;

  logic              clock = 1'b0;
  logic              clear;
  logic [NS-1:0]     src_out;
  logic [NS*DW-1:0]  src_data;
  logic              bus_ack;
  logic [DW-1:0]     BusMuxOut;
  logic              bus_valid;
  logic [SW-1:0]     bus_sel;
  logic              busy;
  logic              contention;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  bus_mux_driver #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .SEL_WIDTH  (SW),
    .TIMEOUT    (15)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .src_out     (src_out),
    .src_data    (src_data),
    .bus_ack     (bus_ack),
    .BusMuxOut   (BusMuxOut),
    .bus_valid   (bus_valid),
    .bus_sel     (bus_sel),
    .busy        (busy),
    .contention  (contention),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    src_data[i*DW +: DW] = w;
  endtask

  initial begin
    clear    = 1'b1;
    src_out  = NS'($urandom);
    src_data = '0;
    for (int i = 0; i < NS; i++) set_word(i, $urandom);
    bus_ack  = 1'b1;
    step();
    chk("rst_out", BusMuxOut, 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'h0);
    chk("rst_sel", 32'(bus_sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cont", 32'(contention), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);

    clear   = 1'b0;
    src_out = '0;
    bus_ack = 1'b0;
    step();
    chk("idle_valid", 32'(bus_valid), 32'h0);

    set_word(5, 32'hDEADBEEF);
    src_out = NS'(1) << 5;
    step();
    chk("ld_out", BusMuxOut, 32'hDEADBEEF);
    chk("ld_sel", 32'(bus_sel), 32'd5);
    chk("ld_valid", 32'(bus_valid), 32'h1);
    chk("ld_busy", 32'(busy), 32'h1);
    chk("ld_cont", 32'(contention), 32'h0);

    src_out = '0;
    set_word(5, 32'h0);
    step();
    chk("hold_out", BusMuxOut, 32'hDEADBEEF);
    chk("hold_valid", 32'(bus_valid), 32'h1);

    bus_ack = 1'b1;
    step();
    chk("ack_valid", 32'(bus_valid), 32'h0);
    chk("ack_busy", 32'(busy), 32'h0);
    chk("ack_out", BusMuxOut, 32'hDEADBEEF);
    bus_ack = 1'b0;

    set_word(3, 32'h00000003);
    set_word(7, 32'h00000007);
    src_out = (NS'(1) << 3) | (NS'(1) << 7);
    step();
    chk("ct_sel", 32'(bus_sel), 32'd3);
    chk("ct_out", BusMuxOut, 32'h3);
    chk("ct_flag", 32'(contention), 32'h1);
    src_out = '0;
    bus_ack = 1'b1;
    step();
    chk("ct_ack_valid", 32'(bus_valid), 32'h0);
    chk("ct_sticky1", 32'(contention), 32'h1);
    bus_ack = 1'b0;
    step();
    chk("ct_sticky2", 32'(contention), 32'h1);

    set_word(2, 32'h00000022);
    src_out = NS'(1) << 2;
    step();
    chk("b2b_sel2", 32'(bus_sel), 32'd2);
    chk("b2b_out2", BusMuxOut, 32'h22);
    set_word(20, 32'h12345678);
    src_out = NS'(1) << 20;
    bus_ack = 1'b1;
    step();
    chk("b2b_out20", BusMuxOut, 32'h12345678);
    chk("b2b_sel20", 32'(bus_sel), 32'd20);
    chk("b2b_valid", 32'(bus_valid), 32'h1);
    src_out = '0;
    step();
    chk("b2b_end", 32'(bus_valid), 32'h0);
    bus_ack = 1'b0;

    set_word(1, 32'h00000011);
    src_out = NS'(1) << 1;
    step();
    src_out = '0;
    chk("to_c1", 32'(bus_valid), 32'h1);
    for (int i = 2; i <= 15; i++) begin
      step();
      chk($sformatf("to_c%0d", i), 32'(bus_valid), 32'h1);
    end
    step();
    chk("to_drop", 32'(bus_valid), 32'h0);
    chk("to_busy", 32'(busy), 32'h0);
    chk("to_err", 32'(timeout_err), 32'h1);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_err", 32'(timeout_err), 32'h0);
    chk("clr_cont", 32'(contention), 32'h0);
    src_out = NS'(1) << 1;
    step();
    src_out = '0;
    for (int i = 2; i <= 15; i++) step();
    chk("ta_c15", 32'(bus_valid), 32'h1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("ta_valid", 32'(bus_valid), 32'h0);
    chk("ta_err", 32'(timeout_err), 32'h0);

    set_word(4, 32'h00000044);
    src_out = NS'(1) << 4;
    step();
    chk("mr_load", BusMuxOut, 32'h44);
    clear   = 1'b1;
    bus_ack = 1'b1;
    src_out = NS'(1) << 6;
    step();
    chk("mr_out", BusMuxOut, 32'h0);
    chk("mr_valid", 32'(bus_valid), 32'h0);
    chk("mr_sel", 32'(bus_sel), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    clear   = 1'b0;
    bus_ack = 1'b0;
    src_out = '0;
    step();
    chk("mr_idle", 32'(bus_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
